// File: rtl/ndn_pkg.sv
// Shared NDN packet constants: field widths, packed storage word width,
// field offsets within the packed word {meta, prefix, data}, and a
// saturating 16-bit counter helper.
package ndn_pkg;

    localparam int META_W   = 8;
    localparam int PREFIX_W = 64;
    localparam int DATA_W   = 256;
    localparam int PKT_W    = META_W + PREFIX_W + DATA_W;

    // Field offsets inside one packed storage word, data in the LSBs.
    localparam int DATA_LSB   = 0;
    localparam int PREFIX_LSB = DATA_W;
    localparam int META_LSB   = DATA_W + PREFIX_W;

    // Saturating increment used by the optional statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_rx_fifo_mem.sv
// Packet storage for the SPI RX FIFO: DEPTH x WIDTH register array with one
// synchronous write port and one asynchronous read port. Contents are not
// reset; validity is tracked entirely by the controller's level count.
module spi_rx_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 328
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write the incoming packet word into the addressed entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/spi_rx_packet_fifo.sv
// spi_rx_packet_fifo: buffers RX_valid-qualified packets from spi_interface
// (no backpressure upstream) and re-presents them to the router core on a
// valid/ready handshake with first-word-fall-through head.
// Overflow discards the new packet and pulses drop the following cycle.
// Optional build macro: SPI_RX_FIFO_STATS_EN adds saturating rx_pkt_cnt and
// drop_cnt outputs.
module spi_rx_packet_fifo
    import ndn_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int META_W   = ndn_pkg::META_W,
    parameter int PREFIX_W = ndn_pkg::PREFIX_W,
    parameter int DATA_W   = ndn_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       RX_valid,
    input  logic [META_W-1:0]          packet_meta_data,
    input  logic [PREFIX_W-1:0]        packet_prefix,
    input  logic [DATA_W-1:0]          packet_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [META_W-1:0]          out_meta,
    output logic [PREFIX_W-1:0]        out_prefix,
    output logic [DATA_W-1:0]          out_data,
    output logic                       full,
    output logic                       drop,
`ifdef SPI_RX_FIFO_STATS_EN
    output logic [15:0]                rx_pkt_cnt,
    output logic [15:0]                drop_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int LVL_W    = $clog2(DEPTH + 1);
    localparam int WORD_W   = META_W + PREFIX_W + DATA_W;
    localparam int W_PFX_LSB  = DATA_W;
    localparam int W_META_LSB = DATA_W + PREFIX_W;

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              out_valid_r;
    logic              full_r;
    logic              drop_r;

    logic              pop_s;
    logic              push_s;
    logic              drop_next_s;
    logic [LVL_W-1:0]  level_next_s;
    logic [WORD_W-1:0] wr_word_s;
    logic [WORD_W-1:0] rd_word_s;

    // Handshake decode: a pop frees a slot in the same cycle, so a full FIFO
    // can still accept a packet when the head is being consumed.
    always_comb begin
        pop_s       = out_valid_r & out_ready;
        push_s      = 1'b0;
        drop_next_s = 1'b0;
        if (RX_valid) begin
            if (!full_r || pop_s) begin
                push_s = 1'b1;
            end else begin
                drop_next_s = 1'b1;
            end
        end else begin
            push_s      = 1'b0;
            drop_next_s = 1'b0;
        end
    end

    // Next occupancy: level + push - pop, bounded by construction.
    always_comb begin
        level_next_s = level_r;
        if (push_s && !pop_s) begin
            level_next_s = level_r + {{(LVL_W-1){1'b0}}, 1'b1};
        end else if (pop_s && !push_s) begin
            level_next_s = level_r - {{(LVL_W-1){1'b0}}, 1'b1};
        end else begin
            level_next_s = level_r;
        end
    end

    // Pointer, level and status registers; async reset empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            level_r     <= {LVL_W{1'b0}};
            out_valid_r <= 1'b0;
            full_r      <= 1'b0;
            drop_r      <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            level_r     <= level_next_s;
            out_valid_r <= (level_next_s != {LVL_W{1'b0}});
            full_r      <= (level_next_s == LVL_W'(DEPTH));
            drop_r      <= drop_next_s;
        end
    end

    assign wr_word_s = {packet_meta_data, packet_prefix, packet_data};

    spi_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_word_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_word_s)
    );

    // Head fields are gated to zero whenever the FIFO is empty.
    always_comb begin
        out_meta   = {META_W{1'b0}};
        out_prefix = {PREFIX_W{1'b0}};
        out_data   = {DATA_W{1'b0}};
        if (out_valid_r) begin
            out_meta   = rd_word_s[W_META_LSB +: META_W];
            out_prefix = rd_word_s[W_PFX_LSB +: PREFIX_W];
            out_data   = rd_word_s[0 +: DATA_W];
        end else begin
            out_meta   = {META_W{1'b0}};
            out_prefix = {PREFIX_W{1'b0}};
            out_data   = {DATA_W{1'b0}};
        end
    end

    assign out_valid = out_valid_r;
    assign full      = full_r;
    assign drop      = drop_r;
    assign level     = level_r;

`ifdef SPI_RX_FIFO_STATS_EN
    logic [15:0] rx_pkt_cnt_r;
    logic [15:0] drop_cnt_r;

    // Saturating counters of accepted and discarded packets.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_pkt_cnt_r <= 16'd0;
            drop_cnt_r   <= 16'd0;
        end else begin
            if (push_s) begin
                rx_pkt_cnt_r <= sat_inc16(rx_pkt_cnt_r);
            end
            if (drop_next_s) begin
                drop_cnt_r <= sat_inc16(drop_cnt_r);
            end
        end
    end

    assign rx_pkt_cnt = rx_pkt_cnt_r;
    assign drop_cnt   = drop_cnt_r;
`endif

endmodule

// File: tb/tb_spi_rx_packet_fifo.sv
// Directed self-checking bench for spi_rx_packet_fifo (DEPTH=4).
module tb_spi_rx_packet_fifo;

    logic         clk;
    logic         rst;
    logic         RX_valid;
    logic [7:0]   packet_meta_data;
    logic [63:0]  packet_prefix;
    logic [255:0] packet_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_meta;
    logic [63:0]  out_prefix;
    logic [255:0] out_data;
    logic         full;
    logic         drop;
    logic [2:0]   level;
`ifdef SPI_RX_FIFO_STATS_EN
    logic [15:0]  rx_pkt_cnt;
    logic [15:0]  drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    spi_rx_packet_fifo #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .RX_valid         (RX_valid),
        .packet_meta_data (packet_meta_data),
        .packet_prefix    (packet_prefix),
        .packet_data      (packet_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_meta         (out_meta),
        .out_prefix       (out_prefix),
        .out_data         (out_data),
        .full             (full),
        .drop             (drop),
`ifdef SPI_RX_FIFO_STATS_EN
        .rx_pkt_cnt       (rx_pkt_cnt),
        .drop_cnt         (drop_cnt),
`endif
        .level            (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic [7:0] m, input logic [63:0] p, input logic [255:0] d);
        RX_valid         = 1'b1;
        packet_meta_data = m;
        packet_prefix    = p;
        packet_data      = d;
    endtask

    initial begin
        logic [255:0] here_data;
        here_data        = "here is data";
        rst              = 1'b0;
        RX_valid         = 1'b0;
        out_ready        = 1'b0;
        packet_meta_data = 8'h00;
        packet_prefix    = 64'h0;
        packet_data      = 256'h0;

        // 1. reset
        step();
        step();
        chk("rst_valid", 256'(out_valid), 256'(1'b0));
        chk("rst_level", 256'(level), 256'(3'd0));
        chk("rst_full",  256'(full), 256'(1'b0));
        chk("rst_drop",  256'(drop), 256'(1'b0));
        chk("rst_meta",  256'(out_meta), 256'(8'h00));
        chk("rst_prefix", 256'(out_prefix), 256'(64'h0));
        chk("rst_data",  out_data, 256'h0);
        rst = 1'b1;
        step();
        step();
        chk("idle_valid", 256'(out_valid), 256'(1'b0));
        chk("idle_level", 256'(level), 256'(3'd0));

        // 2. single packet
        set_pkt(8'h28, 64'd129, here_data);
        step();
        RX_valid = 1'b0;
        chk("single_valid", 256'(out_valid), 256'(1'b1));
        chk("single_meta", 256'(out_meta), 256'(8'h28));
        chk("single_prefix", 256'(out_prefix), 256'(64'd129));
        chk("single_data", out_data, here_data);
        chk("single_level", 256'(level), 256'(3'd1));
        step();
        chk("single_hold", 256'(out_prefix), 256'(64'd129));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_pop_valid", 256'(out_valid), 256'(1'b0));
        chk("single_pop_level", 256'(level), 256'(3'd0));
        chk("single_pop_prefix", 256'(out_prefix), 256'(64'h0));

        // 3. fill and overflow
        for (int i = 1; i <= 5; i++) begin
            set_pkt(8'(i), 64'(i), 256'(i * 7 + 3));
            step();
            if (i == 4) begin
                chk("fill_full4", 256'(full), 256'(1'b1));
                chk("fill_drop4", 256'(drop), 256'(1'b0));
            end
        end
        RX_valid = 1'b0;
        chk("ovf_drop", 256'(drop), 256'(1'b1));
        chk("ovf_level", 256'(level), 256'(3'd4));
        chk("ovf_full", 256'(full), 256'(1'b1));
        step();
        chk("ovf_drop_clear", 256'(drop), 256'(1'b0));
`ifdef SPI_RX_FIFO_STATS_EN
        chk("stat_rx_a", 256'(rx_pkt_cnt), 256'(16'd5));
        chk("stat_drop_a", 256'(drop_cnt), 256'(16'd1));
`endif
        for (int i = 1; i <= 4; i++) begin
            chk("drain_prefix", 256'(out_prefix), 256'(64'(i)));
            chk("drain_data", out_data, 256'(i * 7 + 3));
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        chk("drain_level", 256'(level), 256'(3'd0));
        chk("drain_valid", 256'(out_valid), 256'(1'b0));

        // 4. full with simultaneous push and pop
        for (int i = 5; i <= 8; i++) begin
            set_pkt(8'h40, 64'(i), 256'(i));
            step();
        end
        chk("pp_pre_level", 256'(level), 256'(3'd4));
        set_pkt(8'h41, 64'd9, 256'd9);
        out_ready = 1'b1;
        step();
        RX_valid = 1'b0;
        out_ready = 1'b0;
        chk("pp_level", 256'(level), 256'(3'd4));
        chk("pp_full", 256'(full), 256'(1'b1));
        chk("pp_head", 256'(out_prefix), 256'(64'd6));
        step();
        chk("pp_nodrop", 256'(drop), 256'(1'b0));
        out_ready = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            chk("pp_order", 256'(out_prefix), 256'(64'(i)));
            step();
        end
        out_ready = 1'b0;
        chk("pp_empty", 256'(level), 256'(3'd0));

        // 5. wrap-around streaming
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_pkt(8'(i), 64'(100 + i), 256'(1000 + i));
            step();
            chk("wrap_prefix", 256'(out_prefix), 256'(64'(100 + i)));
            chk("wrap_level", 256'(level), 256'(3'd1));
        end
        RX_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("wrap_end_level", 256'(level), 256'(3'd0));
        chk("wrap_end_valid", 256'(out_valid), 256'(1'b0));
`ifdef SPI_RX_FIFO_STATS_EN
        chk("stat_rx_b", 256'(rx_pkt_cnt), 256'(16'd20));
        chk("stat_drop_b", 256'(drop_cnt), 256'(16'd1));
`endif

        // 6. asynchronous reset mid-operation
        for (int i = 20; i <= 22; i++) begin
            set_pkt(8'h11, 64'(i), 256'(i));
            step();
        end
        RX_valid = 1'b0;
        chk("mid_level", 256'(level), 256'(3'd3));
        #3;
        rst = 1'b0;
        #1;
        chk("async_valid", 256'(out_valid), 256'(1'b0));
        chk("async_level", 256'(level), 256'(3'd0));
        chk("async_prefix", 256'(out_prefix), 256'(64'h0));
        step();
        rst = 1'b1;
        step();
        set_pkt(8'h55, 64'hAA, 256'hBEEF);
        step();
        RX_valid = 1'b0;
        chk("post_valid", 256'(out_valid), 256'(1'b1));
        chk("post_prefix", 256'(out_prefix), 256'(64'hAA));
        chk("post_level", 256'(level), 256'(3'd1));
`ifdef SPI_RX_FIFO_STATS_EN
        chk("stat_rx_c", 256'(rx_pkt_cnt), 256'(16'd1));
        chk("stat_drop_c", 256'(drop_cnt), 256'(16'd0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
